// File: rtl/uart_mem_loader.sv
// UART memory loader: receives a block of bytes into data RAM, runs the CPU,
// then streams a RAM window back out over the UART with an optional checksum.
module uart_mem_loader #(
  parameter int ADDR_W      = 16,
  parameter int LOAD_BASE   = 0,
  parameter int LOAD_LEN    = 65536,
  parameter int DUMP_BASE   = 0,
  parameter int DUMP_LEN    = 65536,
  parameter int CSUM_EN     = 1,
  parameter int CPU_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_byte,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              cpu_enable,
  input  logic              cpu_finish,
  output logic              busy,
  output logic              error,
  output logic [7:0]        led,
  output logic [3:0]        state_dbg
);

  // Handshakes: rx_done is a one-cycle valid strobe qualifying rx_byte; tx_send
  // is a one-cycle start strobe accepted only when tx_ready is high, after which
  // tx_ready drops while the byte is shifted out and rises again when idle.

  typedef enum logic [3:0] {
    LOAD_WAIT = 4'd0,
    LOAD_WR   = 4'd1,
    LOAD_NEXT = 4'd2,
    RUN       = 4'd3,
    DUMP_ADDR = 4'd4,
    DUMP_RD   = 4'd5,
    DUMP_SEND = 4'd6,
    DUMP_BUSY = 4'd7,
    DUMP_IDLE = 4'd8,
    CSUM_SEND = 4'd9,
    CSUM_BUSY = 4'd10,
    CSUM_IDLE = 4'd11,
    FINISH    = 4'd12
  } state_t;

  localparam int                CW          = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] DUMP_BASE_A = ADDR_W'(DUMP_BASE);
  localparam logic [CW-1:0]     LOAD_LEN_C  = CW'(LOAD_LEN);
  localparam logic [CW-1:0]     DUMP_LEN_C  = CW'(DUMP_LEN);
  localparam bit                WD_EN       = (CPU_TIMEOUT != 0);
  localparam logic [31:0]       WD_LIMIT    = 32'(CPU_TIMEOUT - 1);
  localparam bit                CSUM_ON     = (CSUM_EN != 0);

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [7:0]          csum_q, csum_d;
  logic [31:0]         wd_q, wd_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_din_q, mem_din_d;
  logic [7:0]          led_q, led_d;
  logic                error_q, error_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD_WAIT;
      count_q    <= '0;
      csum_q     <= '0;
      wd_q       <= '0;
      tx_data_q  <= '0;
      mem_addr_q <= LOAD_BASE_A;
      mem_din_q  <= '0;
      led_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      wd_q       <= wd_d;
      tx_data_q  <= tx_data_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      led_q      <= led_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    csum_d     = csum_q;
    wd_d       = wd_q;
    tx_data_d  = tx_data_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    led_d      = led_q;
    error_d    = error_q;

    unique case (state_q)
      LOAD_WAIT: begin
        if (rx_done) begin
          mem_din_d  = rx_byte;
          led_d      = rx_byte;
          error_d    = 1'b0;
          mem_addr_d = LOAD_BASE_A + count_q[ADDR_W-1:0];
          state_d    = LOAD_WR;
        end
      end
      LOAD_WR: begin
        count_d = count_q + 1'b1;
        state_d = LOAD_NEXT;
      end
      LOAD_NEXT: begin
        if (count_q == LOAD_LEN_C) begin
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = LOAD_WAIT;
        end
      end
      RUN: begin
        wd_d = wd_q + 32'd1;
        // The read address is launched on entry to DUMP_ADDR so the synchronous
        // RAM output is already valid by the time DUMP_RD captures it.
        if (cpu_finish) begin
          mem_addr_d = DUMP_BASE_A + count_q[ADDR_W-1:0];
          state_d    = DUMP_ADDR;
        end else if (WD_EN && wd_q == WD_LIMIT) begin
          error_d    = 1'b1;
          mem_addr_d = DUMP_BASE_A + count_q[ADDR_W-1:0];
          state_d    = DUMP_ADDR;
        end
      end
      DUMP_ADDR: begin
        mem_addr_d = DUMP_BASE_A + count_q[ADDR_W-1:0];
        state_d    = DUMP_RD;
      end
      DUMP_RD: begin
        tx_data_d = mem_dout;
        led_d     = mem_dout;
        csum_d    = csum_q + mem_dout;
        state_d   = DUMP_SEND;
      end
      DUMP_SEND: state_d = DUMP_BUSY;
      DUMP_BUSY: begin
        if (!tx_ready) state_d = DUMP_IDLE;
      end
      DUMP_IDLE: begin
        if (tx_ready) begin
          count_d = count_q + 1'b1;
          if (count_d == DUMP_LEN_C) begin
            if (CSUM_ON) begin
              tx_data_d = csum_q;
              state_d   = CSUM_SEND;
            end else begin
              state_d = FINISH;
            end
          end else begin
            mem_addr_d = DUMP_BASE_A + count_d[ADDR_W-1:0];
            state_d    = DUMP_ADDR;
          end
        end
      end
      CSUM_SEND: state_d = CSUM_BUSY;
      CSUM_BUSY: begin
        if (!tx_ready) state_d = CSUM_IDLE;
      end
      CSUM_IDLE: begin
        if (tx_ready) state_d = FINISH;
      end
      FINISH: begin
        count_d    = '0;
        csum_d     = '0;
        wd_d       = '0;
        led_d      = '0;
        mem_addr_d = LOAD_BASE_A;
        state_d    = LOAD_WAIT;
      end
      default: state_d = LOAD_WAIT;
    endcase
  end

  assign tx_send    = (state_q == DUMP_SEND) || (state_q == CSUM_SEND);
  assign tx_data    = tx_data_q;
  assign mem_we     = (state_q == LOAD_WR);
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign cpu_enable = (state_q == RUN);
  assign busy       = (state_q != LOAD_WAIT);
  assign error      = error_q;
  // A pending watchdog error lights the top LED whenever the CPU is not running.
  assign led        = (state_q == RUN) ? 8'hFF : {led_q[7] | error_q, led_q[6:0]};
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: wrapped 4-byte load/dump with checksum,
// watchdog, finish/timeout tie, slow transmitter and reset mid-dump.
module tb_uart_mem_loader;

  localparam int ADDR_W = 4;
  localparam int NEVER  = -1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_done = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              tx_send;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout = 8'h00;
  logic              cpu_enable;
  logic              cpu_finish = 1'b0;
  logic              busy;
  logic              error;
  logic [7:0]        led;
  logic [3:0]        state_dbg;

  uart_mem_loader #(
    .ADDR_W(ADDR_W), .LOAD_BASE(14), .LOAD_LEN(4), .DUMP_BASE(14), .DUMP_LEN(4),
    .CSUM_EN(1), .CPU_TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_byte(rx_byte),
    .tx_send(tx_send), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .cpu_enable(cpu_enable), .cpu_finish(cpu_finish), .busy(busy), .error(error),
    .led(led), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // RAM model with one cycle of read latency
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  // Transmitter model: tx_ready low for tx_busy_len cycles after each start
  int tx_busy_len = 3;
  int tx_cnt = 0;
  always @(posedge clk) begin
    if (tx_send) begin
      tx_ready <= 1'b0;
      tx_cnt   <= tx_busy_len;
    end else if (!tx_ready) begin
      if (tx_cnt <= 1) tx_ready <= 1'b1;
      else tx_cnt <= tx_cnt - 1;
    end
  end

  // Monitor
  logic [7:0]        got_tx[$];
  logic [7:0]        got_led[$];
  logic [ADDR_W-1:0] we_addr[$];
  logic [7:0]        we_data[$];
  logic [7:0]        exp_q[$];
  logic [7:0]        hold_byte = 8'h00;
  logic              prev_send = 1'b0, prev_we = 1'b0;
  logic              dbl_send = 1'b0, dbl_we = 1'b0, stable_err = 1'b0;
  int                run_cnt = 0;

  always @(negedge clk) begin
    if (tx_send) begin
      got_tx.push_back(tx_data);
      got_led.push_back(led);
      hold_byte <= tx_data;
      if (prev_send) dbl_send <= 1'b1;
    end else if (!tx_ready && tx_data !== hold_byte) begin
      stable_err <= 1'b1;
    end
    prev_send <= tx_send;
    if (mem_we) begin
      we_addr.push_back(mem_addr);
      we_data.push_back(mem_din);
      if (prev_we) dbl_we <= 1'b1;
    end
    prev_we <= mem_we;
    if (cpu_enable) run_cnt <= run_cnt + 1;
  end

  // Scoreboard
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0][7:0] data;  // data[3] is sent first
    int              fin_delay;
    int              busy_len;
    logic [7:0]      csum;
    int              run_len;
    logic            err;
  } vec_t;

  vec_t tbl[6];

  task automatic clear_monitor();
    got_tx.delete(); got_led.delete(); we_addr.delete(); we_data.delete(); exp_q.delete();
    dbl_send = 1'b0; dbl_we = 1'b0; stable_err = 1'b0; run_cnt = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 0);
    check({tag, "_tx_send"}, 32'(tx_send), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 14);
    check({tag, "_mem_din"}, 32'(mem_din), 0);
    check({tag, "_cpu_enable"}, 32'(cpu_enable), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_led"}, 32'(led), 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (12) @(negedge clk);
    rx_byte = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic load_and_run(input vec_t v);
    int n;
    for (int i = 0; i < 4; i++) begin
      send_byte(v.data[3-i]);
      if (i == 0) check("err_clear_first_byte", 32'(error), 0);
    end
    n = 0;
    while (!cpu_enable && n < 20) begin @(negedge clk); n++; end
    check("cpu_start", 32'(cpu_enable), 1);
    check("led_run", 32'(led), 32'hFF);
    if (v.fin_delay != NEVER) begin
      repeat (v.fin_delay) @(negedge clk);
      cpu_finish = 1'b1;
    end
    n = 0;
    while (cpu_enable && n < 300) begin @(negedge clk); n++; end
    check("cpu_release", 32'(cpu_enable), 0);
    cpu_finish = 1'b0;
  endtask

  task automatic run_vector(input int idx);
    vec_t v;
    int   n;
    logic [3:0] a;
    v = tbl[idx];
    tx_busy_len = v.busy_len;
    clear_monitor();
    load_and_run(v);
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check("dump_done", 32'(busy), 0);
    check("run_len", 32'(run_cnt), 32'(v.run_len));
    check("error_flag", 32'(error), 32'(v.err));
    check("we_count", 32'(we_addr.size()), 4);
    check("we_width", 32'(dbl_we), 0);
    for (int i = 0; i < 4 && i < we_addr.size(); i++) begin
      a = 4'(14 + i);
      check("we_addr", 32'(we_addr[i]), 32'(a));
      check("we_data", 32'(we_data[i]), 32'(v.data[3-i]));
      check("ram_word", 32'(ram[a]), 32'(v.data[3-i]));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(v.data[3-i]);
    exp_q.push_back(v.csum);
    check("tx_count", 32'(got_tx.size()), 5);
    for (int i = 0; i < 4 && i < got_led.size(); i++)
      check("led_dump", 32'(got_led[i]), 32'(v.data[3-i] | (v.err ? 8'h80 : 8'h00)));
    while (exp_q.size() > 0 && got_tx.size() > 0)
      check("tx_byte", 32'(got_tx.pop_front()), 32'(exp_q.pop_front()));
    check("tx_single_pulse", 32'(dbl_send), 0);
    check("tx_data_stable", 32'(stable_err), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    tbl[0] = '{data: {8'h01, 8'h02, 8'h03, 8'h04}, fin_delay: 20,    busy_len: 3,  csum: 8'h0A, run_len: 21,  err: 1'b0};
    tbl[1] = '{data: {8'hAA, 8'hBB, 8'hCC, 8'hDD}, fin_delay: 5,     busy_len: 50, csum: 8'h0E, run_len: 6,   err: 1'b0};
    tbl[2] = '{data: {8'h10, 8'h20, 8'h30, 8'hF0}, fin_delay: NEVER, busy_len: 2,  csum: 8'h50, run_len: 100, err: 1'b1};
    tbl[3] = '{data: {8'h55, 8'h66, 8'h77, 8'h88}, fin_delay: 99,    busy_len: 4,  csum: 8'hBA, run_len: 100, err: 1'b0};
    tbl[4] = '{data: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, fin_delay: 0,     busy_len: 1,  csum: 8'hFC, run_len: 1,   err: 1'b0};
    tbl[5] = '{data: {8'h09, 8'h08, 8'h07, 8'h06}, fin_delay: 2,     busy_len: 3,  csum: 8'h1E, run_len: 3,   err: 1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    for (int k = 0; k < 5; k++) run_vector(k);
    check("error_retained_idle", 32'(error), 0);

    // Reset during DUMP_BUSY of the second byte, then a fresh load/dump
    tx_busy_len = 20;
    clear_monitor();
    begin
      vec_t stale;
      stale = '{data: {8'h11, 8'h22, 8'h33, 8'h44}, fin_delay: 3, busy_len: 20, csum: 8'h00, run_len: 4, err: 1'b0};
      load_and_run(stale);
    end
    n = 0;
    begin
      int sends = 0;
      while (sends < 2 && n < 500) begin
        @(negedge clk);
        n++;
        if (tx_send) sends++;
      end
      check("mid_reset_reach_second_send", 32'(sends), 2);
    end
    @(negedge clk);
    check("mid_reset_in_dump_busy", 32'(state_dbg), 7);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid_reset");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run_vector(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Parametrised successor to the top-level UART I/O sequencer.
- Streams a configurable number of bytes from uart_rx into data RAM, then hands the RAM to the CPU and waits for cpu_finish (with an optional watchdog).
- Streams a configurable window of RAM back through uart_tx, optionally followed by a checksum byte, then re-arms for the next load.
- Owns the RAM port mux select. Sits between uart_rx, uart_tx, data_ram and CPU_Top.

Parameters:
- ADDR_W, 16, data RAM address width.
- LOAD_BASE, 0, first RAM address written during load.
- LOAD_LEN, 65536, bytes received per load (1..2^ADDR_W).
- DUMP_BASE, 0, first RAM address read during dump.
- DUMP_LEN, 65536, bytes transmitted per dump (1..2^ADDR_W).
- CSUM_EN, 1, 1 = append checksum byte after dump.
- CPU_TIMEOUT, 0, watchdog in clk cycles; 0 = disabled. Counter is 32 bits.

Ports:
- clk  in  1  system clock (divided clock in the top level)
- reset  in  1  synchronous, active-high
- rx_done  in  1  one-cycle pulse, rx_byte valid
- rx_byte  in  8  received byte
- tx_send  out  1  one-cycle start pulse to uart_tx
- tx_data  out  8  byte to transmit, stable from pulse until tx_ready returns high
- tx_ready  in  1  high when transmitter idle
- mem_we  out  1  RAM write enable (host side)
- mem_addr  out  ADDR_W  RAM address (host side)
- mem_din  out  8  RAM write data
- mem_dout  in  8  RAM read data, 1-cycle synchronous latency
- cpu_enable  out  1  high = CPU runs and owns RAM port; also the mux select
- cpu_finish  in  1  CPU done, level
- busy  out  1  high in any state except LOAD_WAIT
- error  out  1  sticky watchdog flag; cleared by reset or the first byte of the next load
- led  out  8  status display

Behaviour:
- Clock and reset:
  - One clock, clk. All state changes occur on the rising edge only.
  - reset is synchronous and active-high, and wins over every other event, including mid-operation.
  - Reset values: state=LOAD_WAIT, tx_send=0, tx_data=0, mem_we=0, mem_addr=LOAD_BASE, mem_din=0, cpu_enable=0, busy=0, error=0, led=0, byte counter=0, checksum=0, watchdog=0.
- Counters and addresses:
  - Byte counter is ADDR_W+1 bits.
  - Addresses are computed as base+count mod 2^ADDR_W, so they wrap silently.
- LOAD_WAIT:
  - On rx_done: mem_din<=rx_byte, led<=rx_byte, error<=0, go to LOAD_WR. Otherwise stay.
- LOAD_WR:
  - mem_we=1 for exactly 1 cycle at LOAD_BASE+count.
  - Then count++ and go to LOAD_NEXT.
- LOAD_NEXT:
  - If count==LOAD_LEN: count<=0, go to RUN.
  - Otherwise go to LOAD_WAIT.
  - rx_done pulses arriving in LOAD_WR/LOAD_NEXT are dropped. The sender's byte spacing (≥10 bit times) guarantees this never happens in use.
- RUN:
  - cpu_enable=1, led=8'hFF, watchdog increments each cycle.
  - If cpu_finish=1: cpu_enable<=0, go to DUMP_ADDR.
  - Else if CPU_TIMEOUT!=0 and watchdog==CPU_TIMEOUT-1: cpu_enable<=0, error<=1, go to DUMP_ADDR.
  - If both are true in the same cycle, cpu_finish wins and error stays 0.
  - rx_done is ignored in RUN and in all dump states.
- DUMP_ADDR:
  - mem_addr<=DUMP_BASE+count, then go to DUMP_RD (one RAM latency cycle).
- DUMP_RD:
  - tx_data<=mem_dout, led<=mem_dout, checksum<=checksum+mem_dout (mod 256).
  - Then go to DUMP_SEND.
- DUMP_SEND:
  - tx_send=1 for 1 cycle, then go to DUMP_BUSY.
- DUMP_BUSY:
  - Wait for tx_ready=0, then go to DUMP_IDLE.
- DUMP_IDLE:
  - Wait for tx_ready=1, then count++.
  - If count+1==DUMP_LEN: go to CSUM_SEND when CSUM_EN, else to FINISH.
  - Otherwise go to DUMP_ADDR.
- CSUM_SEND:
  - tx_data<=checksum, 1-cycle tx_send.
  - Then wait through CSUM_BUSY/CSUM_IDLE with the same tx_ready rules as the dump states.
- FINISH:
  - count<=0, checksum<=0, watchdog<=0, led<=0, mem_addr<=LOAD_BASE.
  - Then go to LOAD_WAIT; error is retained.
- Outputs:
  - When error=1 outside RUN, led[7] is forced to 1.
  - mem_we is 0 in every state except LOAD_WR.
  - tx_send is never high in two consecutive cycles.

Test Plan:
- Basic round trip (LOAD_LEN=DUMP_LEN=4, CSUM_EN=1): send 01 02 03 04, cpu_finish 20 cycles after cpu_enable rises -> RAM[0..3]=01..04; cpu_enable high exactly until finish; TX stream 01 02 03 04 0A.
- Wrap-around (ADDR_W=4, LOAD_BASE=14, LOAD_LEN=4): load AA BB CC DD -> writes to addresses 14, 15, 0, 1; exactly 4 mem_we pulses, each 1 cycle.
- Watchdog (CPU_TIMEOUT=100, cpu_finish held 0): -> cpu_enable low after exactly 100 cycles, error=1, dump still runs, led[7]=1 during dump; the next load's first byte clears error.
- Finish/timeout tie: cpu_finish asserted on the cycle the watchdog expires -> error stays 0.
- Slow transmitter: uart_tx model holds tx_ready low for 50 cycles per byte -> one tx_send per byte, tx_data stable for the whole busy period, no bytes skipped.
- Reset mid-operation: assert reset during DUMP_BUSY of byte 2, then reload -> outputs return to their reset values next edge; fresh load/dump is correct and the checksum does not include stale bytes.
